apb_reg_completer: RTL and testbench
====================================

Name: apb_reg_completer

Overview:
APB completer (slave) that answers transfers from the team's APB requester/FIFO front end. It holds a bank of 32-bit registers with byte strobes and a read-only ID word. It inserts a programmable number of wait states and flags bad accesses with an error response. It is the responder end of the same APB link that the APB_System bench drives from the read/write request side.

Parameters:
ADDR_W, 32, width of paddr_i
NUM_REGS, 16, number of 32-bit registers (power of two, 2..256); register 0 is the read-only ID
WAIT_CYCLES, 2, access-phase wait states before pready_o (0..15)
ID_VALUE, 32'hA9B0_0001, constant returned by register 0

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset asserted)
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  1 = write, 0 = read
paddr_i  in  ADDR_W  byte address
pwdata_i  in  32  write data
pstrb_i  in  4  write byte strobes, bit n enables pwdata_i[8n+7:8n]
pready_o  out  1  transfer complete
prdata_o  out  32  read data, valid only while pready_o=1
pslverr_o  out  1  error response, valid only while pready_o=1

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, wait counter=0, pready_o=0, prdata_o=0, pslverr_o=0, registers 1..NUM_REGS-1 = 0. Reset asserted mid-transfer aborts the transfer: no write, and pready_o stays 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE: psel_i=1 and penable_i=0 (setup phase) at an edge latches addr/write/wdata/strb and loads counter=WAIT_CYCLES.
  - WAIT_CYCLES=0: go to DONE.
  - Otherwise: go to WAIT.
- WAIT: each edge with psel_i=1 and penable_i=1 decrements the counter. When the counter reaches 1, the edge moves to DONE.
- DONE: pready_o=1 for exactly one cycle. prdata_o and pslverr_o are driven in the same cycle. The edge ending DONE commits the write (if legal) and returns to IDLE.
- Latency: setup cycle T0, first access cycle T1, pready_o high in cycle T1+WAIT_CYCLES. All outputs are registered.
- Back-to-back transfers: a new setup phase in the cycle after DONE is accepted from IDLE with no gap.
- Decode: index = paddr_i[2 +: log2(NUM_REGS)].
- Error cases (pslverr_o=1, no register change, prdata_o=0):
  - paddr_i >= NUM_REGS*4
  - paddr_i[1:0] != 0
  - write to index 0
- Read of index 0 returns ID_VALUE.
- Writes merge by byte: reg[byte n] = pstrb_i[n] ? pwdata_i byte n : old byte. pstrb_i=0 is a legal write that leaves the register unchanged (pslverr_o=0).
- Reads ignore pstrb_i.
- Protocol violation: psel_i=0 while in WAIT or DONE aborts to IDLE. No write, outputs return to 0.
- Outside DONE: prdata_o=0, pslverr_o=0, pready_o=0.
- Inputs are sampled from the latched setup values. Changes to paddr/pwdata during the access phase are ignored.

Decomposition:
- Shared package apb_pkg holds:
  - state enum typedef (IDLE/WAIT/DONE)
  - APB_DATA_W=32 and APB_STRB_W=4
  - ID_VALUE default
  - error-decode helper function
- One sub-module: apb_reg_bank.
  - Contains the register storage with byte-strobe write and combinational read.
  - Register 0 is hard-wired to ID_VALUE.
- The FSM, wait counter and address decode stay in apb_reg_completer.

Test Plan:
- Reset then read 0x00 (WAIT_CYCLES=2) -> pready_o=0 in T1,T2, =1 in T3 with prdata_o=0xA9B00001, pslverr_o=0.
- Write 0x04 data 0xDEADBEEF strb 4'hF, then read 0x04 -> 0xDEADBEEF, pslverr_o=0. Read 0x08 -> 0x00000000.
- Partial strobe: after the above, write 0x04 data 0x11223344 strb 4'b0101 -> read 0x04 returns 0xDE22BE44.
- Error cases:
  - Write 0x40 (NUM_REGS=16) -> pslverr_o=1, no register changed.
  - Read 0x06 -> pslverr_o=1, prdata_o=0.
  - Write 0x00 data 0x0 -> pslverr_o=1, read 0x00 still 0xA9B00001.
- Abort: write 0x0C data 0x12345678, drop psel_i after one access cycle -> pready_o never 1, read 0x0C = 0. Repeat with reset=0 mid-wait -> same result, all outputs 0.
- WAIT_CYCLES=0 build, back-to-back write 0x08=0xCAFEF00D then read 0x08 -> each pready_o in first access cycle, read returns 0xCAFEF00D.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types, widths and decode helpers for the register completer.
package apb_pkg;

    localparam int          APB_DATA_W   = 32;
    localparam int          APB_STRB_W   = 4;
    localparam logic [31:0] APB_ID_VALUE = 32'hA9B0_0001;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } apb_state_e;

    // Transfer attributes captured in the setup phase.
    typedef struct packed {
        logic                  write;
        logic                  err;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_req_t;

    // Error for misaligned, out-of-range, or writes to the read-only ID word.
    function automatic logic apb_access_err(input logic [1:0] lsb,
                                            input logic       above_range,
                                            input logic       write,
                                            input logic       id_hit);
        return (lsb != 2'b00) || above_range || (write && id_hit);
    endfunction

endpackage

// File: rtl/apb_reg_completer_if.sv
// APB link between a requester (master) and the register completer (slave).
interface apb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_W-1:0]     paddr_i;
    logic [APB_DATA_W-1:0] pwdata_i;
    logic [APB_STRB_W-1:0] pstrb_i;
    logic                  pready_o;
    logic [APB_DATA_W-1:0] prdata_o;
    logic                  pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/apb_reg_completer_reg_bank.sv
// Register storage with byte-strobe writes and a combinational read port.
// Entry 0 is the constant ID word and is never stored.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter int          IDX_W    = $clog2(NUM_REGS),
    parameter logic [31:0] ID_VALUE = APB_ID_VALUE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [APB_STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);
    logic [NUM_REGS-1:1][APB_DATA_W-1:0] regs;
    logic [NUM_REGS-1:0][APB_DATA_W-1:0] rd_vec;

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs <= '0;
        end else if (we) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                for (int b = 0; b < APB_STRB_W; b++) begin
                    if (widx == IDX_W'(r) && wstrb[b])
                        regs[r][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_vec[0] = ID_VALUE;
        for (int r = 1; r < NUM_REGS; r++)
            rd_vec[r] = regs[r];
    end

    assign rdata = rd_vec[ridx];

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer: setup-phase capture, programmable wait states, one-cycle
// registered response, and write commit on the edge that ends DONE.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = APB_ID_VALUE
) (
    input  logic clk,
    input  logic reset,
    apb_if.slave apb
);
    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    apb_state_e            state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    apb_req_t              req, req_nxt, req_set;
    logic [IDX_W-1:0]      idx, idx_nxt, idx_set, ridx;
    logic                  pready_q, pready_nxt;
    logic                  pslverr_q, pslverr_nxt;
    logic [APB_DATA_W-1:0] prdata_q, prdata_nxt, rdata;
    logic                  go_done, bank_we, setup, above_range;
    logic [ADDR_W-1:0]     addr;

    assign addr        = apb.paddr_i;
    assign setup       = apb.psel_i && !apb.penable_i;
    assign above_range = (addr >> (IDX_W + 2)) != '0;
    assign idx_set     = addr[2 +: IDX_W];

    always_comb begin
        req_set.write = apb.pwrite_i;
        req_set.err   = apb_access_err(addr[1:0], above_range, apb.pwrite_i,
                                       idx_set == '0);
        req_set.wdata = apb.pwdata_i;
        req_set.strb  = apb.pstrb_i;
    end

    // In IDLE the response may be produced from the transfer being captured.
    assign ridx = (state == IDLE) ? idx_set : idx;

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we),
        .widx  (idx),
        .wdata (req.wdata),
        .wstrb (req.strb),
        .ridx  (ridx),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req       <= '0;
            idx       <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req       <= req_nxt;
            idx       <= idx_nxt;
            pready_q  <= pready_nxt;
            pslverr_q <= pslverr_nxt;
            prdata_q  <= prdata_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        req_nxt     = req;
        idx_nxt     = idx;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        prdata_nxt  = '0;
        go_done     = 1'b0;
        bank_we     = 1'b0;

        case (state)
            IDLE: begin
                if (setup) begin
                    req_nxt = req_set;
                    idx_nxt = idx_set;
                    cnt_nxt = WAIT_INIT;
                    if (WAIT_CYCLES == 0) go_done   = 1'b1;
                    else                  state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!apb.psel_i) begin
                    state_nxt = IDLE;
                end else if (apb.penable_i) begin
                    if (cnt <= 4'd1) go_done = 1'b1;
                    else             cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                // A dropped select here is a protocol abort: nothing commits.
                state_nxt = IDLE;
                bank_we   = apb.psel_i && req.write && !req.err;
            end
            default: state_nxt = IDLE;
        endcase

        if (go_done) begin
            state_nxt   = DONE;
            pready_nxt  = 1'b1;
            pslverr_nxt = req_nxt.err;
            prdata_nxt  = (!req_nxt.write && !req_nxt.err) ? rdata : '0;
        end
    end

    assign apb.pready_o  = pready_q;
    assign apb.pslverr_o = pslverr_q;
    assign apb.prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench: a WAIT_CYCLES=2 completer on bus0 and a zero-wait one on bus1.
module tb_apb_reg_completer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    apb_if #(.ADDR_W(32)) bus0 ();
    apb_if #(.ADDR_W(32)) bus1 ();

    apb_reg_completer #(.ADDR_W(32), .NUM_REGS(16), .WAIT_CYCLES(2),
                        .ID_VALUE(32'hA9B0_0001))
        u_dut (.clk(clk), .reset(reset), .apb(bus0));

    apb_reg_completer #(.ADDR_W(32), .NUM_REGS(16), .WAIT_CYCLES(0),
                        .ID_VALUE(32'hA9B0_0001))
        u_dut0 (.clk(clk), .reset(reset), .apb(bus1));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int b, input logic sel, input logic en,
                         input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (b == 0) begin
            bus0.psel_i = sel; bus0.penable_i = en; bus0.pwrite_i = w;
            bus0.paddr_i = a;  bus0.pwdata_i = d;   bus0.pstrb_i = s;
        end else begin
            bus1.psel_i = sel; bus1.penable_i = en; bus1.pwrite_i = w;
            bus1.paddr_i = a;  bus1.pwdata_i = d;   bus1.pstrb_i = s;
        end
    endtask

    task automatic sample(input int b, output logic rdy,
                          output logic [31:0] rd, output logic er);
        if (b == 0) begin
            rdy = bus0.pready_o; rd = bus0.prdata_o; er = bus0.pslverr_o;
        end else begin
            rdy = bus1.pready_o; rd = bus1.prdata_o; er = bus1.pslverr_o;
        end
    endtask

    // Setup, then access phase with pwdata scrambled to confirm it is ignored.
    task automatic xfer(input int b, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er,
                        output int waits);
        logic        rdy, e;
        logic [31:0] r;
        @(posedge clk); #1;
        drive(b, 1'b1, 1'b0, w, a, d, s);
        @(posedge clk); #1;
        drive(b, 1'b1, 1'b1, w, a, ~d, s);
        waits = 99; rd = 32'hBAD0_BAD0; er = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample(b, rdy, r, e);
            if (rdy) begin
                waits = i; rd = r; er = e;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic xfer_chk(input string tag, input int b, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_wait);
        logic [31:0] rd;
        logic        er;
        int          waits;
        xfer(b, w, a, d, s, rd, er, waits);
        check({tag, "_lat"}, waits, exp_wait);
        check({tag, "_data"}, rd, exp_rd);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic go_idle(input int b);
        @(posedge clk); #1;
        drive(b, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    logic        rdy, er;
    logic [31:0] rd;
    int          seen;

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample(0, rdy, rd, er);
        check("rst_pready", {31'd0, rdy}, 32'd0);
        check("rst_prdata", rd, 32'd0);
        check("rst_pslverr", {31'd0, er}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // bus0: WAIT_CYCLES=2, response in the third access cycle
        xfer_chk("rd_id",       0, 1'b0, 32'h00, 32'h0,        4'h0, 32'hA9B0_0001, 1'b0, 2);
        xfer_chk("wr_04",       0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,         1'b0, 2);
        xfer_chk("rd_04",       0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF,  1'b0, 2);
        xfer_chk("rd_08",       0, 1'b0, 32'h08, 32'h0,        4'hF, 32'h0,         1'b0, 2);
        xfer_chk("wr_04_part",  0, 1'b1, 32'h04, 32'h11223344, 4'h5, 32'h0,         1'b0, 2);
        xfer_chk("rd_04_part",  0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDE22BE44,  1'b0, 2);
        xfer_chk("wr_40",       0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0,         1'b1, 2);
        xfer_chk("wr_44",       0, 1'b1, 32'h44, 32'hFFFFFFFF, 4'hF, 32'h0,         1'b1, 2);
        xfer_chk("rd_04_oor",   0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDE22BE44,  1'b0, 2);
        xfer_chk("rd_06",       0, 1'b0, 32'h06, 32'h0,        4'h0, 32'h0,         1'b1, 2);
        xfer_chk("rd_44",       0, 1'b0, 32'h44, 32'h0,        4'h0, 32'h0,         1'b1, 2);
        xfer_chk("wr_id",       0, 1'b1, 32'h00, 32'h0,        4'hF, 32'h0,         1'b1, 2);
        xfer_chk("rd_id2",      0, 1'b0, 32'h00, 32'h0,        4'h0, 32'hA9B0_0001, 1'b0, 2);
        xfer_chk("wr_04_nostb", 0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 32'h0,         1'b0, 2);
        xfer_chk("rd_04_nostb", 0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDE22BE44,  1'b0, 2);
        xfer_chk("wr_3c",       0, 1'b1, 32'h3C, 32'h5A5A5A5A, 4'hF, 32'h0,         1'b0, 2);
        xfer_chk("rd_3c",       0, 1'b0, 32'h3C, 32'h0,        4'h0, 32'h5A5A5A5A,  1'b0, 2);
        go_idle(0);

        // select dropped after one access cycle: transfer must vanish
        seen = 0;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h12345678, 4'hF);
        @(negedge clk);
        sample(0, rdy, rd, er);
        seen += int'(rdy);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) begin
            @(negedge clk);
            sample(0, rdy, rd, er);
            seen += int'(rdy);
        end
        check("abort_psel_rdy", seen, 0);
        xfer_chk("rd_0c_abort", 0, 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 2);
        go_idle(0);

        // reset asserted in the middle of the wait
        seen = 0;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        sample(0, rdy, rd, er);
        check("rstmid_pready", {31'd0, rdy}, 32'd0);
        check("rstmid_prdata", rd, 32'd0);
        check("rstmid_pslverr", {31'd0, er}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        xfer_chk("rd_0c_rst", 0, 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0,         1'b0, 2);
        xfer_chk("rd_04_rst", 0, 1'b0, 32'h04, 32'h0, 4'h0, 32'h0,         1'b0, 2);
        xfer_chk("rd_id_rst", 0, 1'b0, 32'h00, 32'h0, 4'h0, 32'hA9B0_0001, 1'b0, 2);
        go_idle(0);

        // bus1: zero wait states, back-to-back transfers
        xfer_chk("w0_wr_08", 1, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 32'h0,         1'b0, 0);
        xfer_chk("w0_rd_08", 1, 1'b0, 32'h08, 32'h0,        4'h0, 32'hCAFEF00D,  1'b0, 0);
        xfer_chk("w0_rd_id", 1, 1'b0, 32'h00, 32'h0,        4'h0, 32'hA9B0_0001, 1'b0, 0);
        xfer_chk("w0_rd_05", 1, 1'b0, 32'h05, 32'h0,        4'h0, 32'h0,         1'b1, 0);
        go_idle(1);
        @(negedge clk);
        sample(1, rdy, rd, er);
        check("w0_idle_pready", {31'd0, rdy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
